fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/ptr_sync_ff.sv | 29 ++
 rtl/fifo_rd_ctrl.sv | 86 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and Gray-code helpers for the read and write pointer controllers.
package fifo_pkg;

  localparam int unsigned AW_DEFAULT          = 4;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Helpers work on a wide container; callers zero-extend in and size-cast the result back.
  localparam int unsigned PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync_ff.sv
// Plain flop chain carrying a Gray pointer into this clock domain; nothing sits between stages.
module ptr_sync_ff #(
  parameter int unsigned W      = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side pointer controller with registered empty/ack/underflow flags.
// Define FIFO_RD_LEVEL_EN to add the registered rd_level occupancy output.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned AW          = AW_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW:0]   wr_ptr_gray,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   rd_ptr_gray,
  output logic          empty,
  output logic          rd_ack,
  output logic          underflow
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [AW:0]   rd_level
`endif
);

  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] rd_bin_q, rd_bin_next;
  logic [PW-1:0] rd_gray_q, rd_gray_next;
  logic [PW-1:0] wq_gray;
  logic          empty_q, rd_ack_q, underflow_q;
  logic          rd_fire;

  ptr_sync_ff #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (wr_ptr_gray),
    .dout (wq_gray)
  );

  assign rd_fire      = rd_en && !empty_q;
  assign rd_bin_next  = rd_bin_q + PW'(rd_fire);
  assign rd_gray_next = PW'(bin2gray(ptr_t'(rd_bin_next)));

  // Empty compares the post-fire pointer so the last read raises it on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      empty_q     <= 1'b1;
      rd_ack_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_next;
      rd_gray_q   <= rd_gray_next;
      empty_q     <= (rd_gray_next == wq_gray);
      rd_ack_q    <= rd_fire;
      underflow_q <= rd_en && empty_q;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] rd_level_q;

  assign wq_bin = PW'(gray2bin(ptr_t'(wq_gray)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_level_q <= '0;
    end else begin
      rd_level_q <= wq_bin - rd_bin_next;
    end
  end

  assign rd_level = rd_level_q;
`endif

  assign rd_addr     = rd_bin_q[AW-1:0];
  assign rd_ptr_gray = rd_gray_q;
  assign empty       = empty_q;
  assign rd_ack      = rd_ack_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl at AW=3, SYNC_STAGES=2 with a modelled synchronous RAM.
module tb_fifo_rd_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned PW = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic [PW-1:0] wr_ptr_gray;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_ptr_gray;
  logic          empty, rd_ack, underflow;
`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] rd_level;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned rd_model = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  ram_q;
  logic [PW-1:0] prev_gray;

  fifo_rd_ctrl #(
    .AW          (AW),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_addr     (rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .empty       (empty),
    .rd_ack      (rd_ack),
    .underflow   (underflow)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level    (rd_level)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM: word at address a holds 8'hA0 + a.
  always @(posedge clk) ram_q <= 8'hA0 + {5'b0, rd_addr};

  function automatic logic [PW-1:0] g(input int unsigned b);
    logic [PW-1:0] t;
    t = b[PW-1:0];
    return t ^ (t >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire();
    exp_q.push_back(8'hA0 + 8'(rd_model % 8));
    rd_en = 1'b1;
    tick();
    rd_model++;
  endtask

  // Monitor: every rd_ack must deliver the next expected RAM word.
  always @(negedge clk) begin
    if (rst === 1'b0 && rd_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        check("ack_data", 32'(ram_q), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    rd_en = 1'b0;
    wr_ptr_gray = '0;
    #3;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_gray", 32'(rd_ptr_gray), 32'd0);
    check("rst_ack", 32'(rd_ack), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_empty", 32'(empty), 32'd1);

    // Fill latency: write pointer to bin 3 right after edge N.
    wr_ptr_gray = 4'b0010;
    tick();
    check("fill_n1_empty", 32'(empty), 32'd1);
    tick();
    check("fill_n2_empty", 32'(empty), 32'd1);
    tick();
    check("fill_n3_empty", 32'(empty), 32'd0);

    // Drain three entries, then one rejected read.
    for (int k = 0; k < 3; k++) begin
      check("drain_addr", 32'(rd_addr), 32'(k));
      fire();
      check("drain_ack", 32'(rd_ack), 32'd1);
      check("drain_empty", 32'(empty), (k == 2) ? 32'd1 : 32'd0);
    end
    tick();
    check("uf_pulse", 32'(underflow), 32'd1);
    check("uf_no_ack", 32'(rd_ack), 32'd0);
    check("uf_addr", 32'(rd_addr), 32'd3);
    check("uf_gray", 32'(rd_ptr_gray), 32'(4'b0010));
    rd_en = 1'b0;
    tick();
    check("uf_clear", 32'(underflow), 32'd0);

    // Reset while a read is firing.
    wr_ptr_gray = g(5);
    repeat (3) tick();
    check("mid_empty", 32'(empty), 32'd0);
    fire();
    @(negedge clk);
    #1;
    check("mid_fire_active", 32'(rd_en && !empty), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_empty_rst", 32'(empty), 32'd1);
    check("mid_addr_rst", 32'(rd_addr), 32'd0);
    check("mid_gray_rst", 32'(rd_ptr_gray), 32'd0);
    check("mid_ack_rst", 32'(rd_ack), 32'd0);
    check("mid_uf_rst", 32'(underflow), 32'd0);
    check("mid_no_x", 32'($isunknown({rd_addr, rd_ptr_gray, empty, rd_ack, underflow})), 32'd0);
    rd_en = 1'b0;
    wr_ptr_gray = '0;
    tick();
    check("mid_ack_after_edge", 32'(rd_ack), 32'd0);
    rst = 1'b0;
    rd_model = 0;
    tick();

    // Wrap: 16 fires with the writer kept five ahead.
    wr_ptr_gray = g(5);
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      wr_ptr_gray = g(rd_model + 5);
      prev_gray = rd_ptr_gray;
      fire();
      check("wrap_gray", 32'(rd_ptr_gray), 32'(g(rd_model)));
      check("wrap_one_bit", 32'($countones(prev_gray ^ rd_ptr_gray)), 32'd1);
      if (rd_model == 8) begin
        check("wrap_half_gray", 32'(rd_ptr_gray), 32'(4'b1100));
        check("wrap_half_addr", 32'(rd_addr), 32'd0);
      end
    end
    check("wrap_full_gray", 32'(rd_ptr_gray), 32'd0);
    rd_en = 1'b0;
    tick();
    tick();

`ifdef FIFO_RD_LEVEL_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_model = 0;
    wr_ptr_gray = g(5);
    repeat (3) tick();
    check("level_full5", 32'(rd_level), 32'd5);
    fire();
    fire();
    check("level_5_2", 32'(rd_level), 32'd3);
    while (rd_model < 14) begin
      wr_ptr_gray = g(rd_model + 4);
      fire();
    end
    rd_en = 1'b0;
    repeat (3) tick();
    check("level_wrap", 32'(rd_level), 32'd3);
    tick();
`endif

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
